// File: rtl/vector_checker_if.sv
// rtl/vector_checker_if.sv - ROM read bus and DUT stimulus/response bus of the vector checker
interface vector_checker_if #(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 1,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   rom_addr;
    logic [IN_W+OUT_W:0] rom_data;
    logic [IN_W-1:0]     dut_in;
    logic [OUT_W-1:0]    dut_out;

    modport master (output rom_addr, output dut_in, input rom_data, input dut_out);
    modport slave  (input rom_addr, input dut_in, output rom_data, output dut_out);
endinterface

// File: rtl/vector_checker.sv
// rtl/vector_checker.sv - walks a test-vector ROM, drives a DUT and counts response mismatches
module vector_checker #(
    parameter int IN_W       = 1,
    parameter int OUT_W      = 1,
    parameter int ADDR_W     = 4,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    vector_checker_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   vec_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, FETCH, SETTLE, CHECK, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX    = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [IN_W-1:0]     dut_in_q, dut_in_d;
    logic [OUT_W-1:0]    exp_q, exp_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W:0]     vec_q, vec_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic                seen_q, seen_d;
    logic                mismatch_q, mismatch_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                rom_valid;
    logic [IN_W-1:0]     rom_stim;
    logic [OUT_W-1:0]    rom_exp;

    assign rom_valid = bus.rom_data[IN_W+OUT_W];
    assign rom_stim  = bus.rom_data[IN_W+OUT_W-1:OUT_W];
    assign rom_exp   = bus.rom_data[OUT_W-1:0];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dut_in_d   = dut_in_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        vec_d      = vec_q;
        first_d    = first_q;
        seen_d     = seen_q;
        mismatch_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    err_d   = '0;
                    vec_d   = '0;
                    first_d = '0;
                    seen_d  = 1'b0;
                end
            end
            FETCH: begin
                // A cleared valid bit terminates the run without being checked
                if (!rom_valid) begin
                    state_d = DONE;
                end else begin
                    dut_in_d = rom_stim;
                    exp_d    = rom_exp;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) state_d = CHECK;
                else               cnt_d   = cnt_q - 8'd1;
            end
            CHECK: begin
                vec_d = vec_q + 1'b1;
                if (bus.dut_out != exp_q) begin
                    mismatch_d = 1'b1;
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (!seen_q) begin
                        seen_d  = 1'b1;
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status flags are decoded from the next state so they register alongside it
        busy_d = (state_d == FETCH) || (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dut_in_q   <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            vec_q      <= '0;
            first_q    <= '0;
            seen_q     <= 1'b0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dut_in_q   <= dut_in_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            vec_q      <= vec_d;
            first_q    <= first_d;
            seen_q     <= seen_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.rom_addr   = idx_q;
    assign bus.dut_in     = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch       = mismatch_q;
    assign err_count      = err_q;
    assign vec_count      = vec_q;
    assign first_err_addr = first_q;
endmodule

// File: tb/tb_vector_checker.sv
// tb/tb_vector_checker.sv - randomized and directed bench for vector_checker
module tb_vector_checker;
    localparam int SA = 2;
    localparam int SB = 3;

    logic clk = 1'b0;
    logic reset, start_a, start_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic       busy_a, done_a, pass_a, mm_a;
    logic [7:0] err_a;
    logic [4:0] vc_a;
    logic [3:0] fe_a;
    logic [2:0] rom_a [16];
    logic       inv_a;

    vector_checker_if #(.IN_W(1), .OUT_W(1), .ADDR_W(4)) bus_a ();
    assign bus_a.rom_data = rom_a[bus_a.rom_addr];
    assign bus_a.dut_out  = inv_a ? ~bus_a.dut_in : bus_a.dut_in;

    vector_checker #(.IN_W(1), .OUT_W(1), .ADDR_W(4), .SETTLE_CYC(SA), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mm_a),
        .err_count(err_a), .vec_count(vc_a), .first_err_addr(fe_a)
    );

    logic       busy_b, done_b, pass_b, mm_b;
    logic [1:0] err_b;
    logic [3:0] vc_b;
    logic [2:0] fe_b;
    logic [4:0] rom_b [8];

    vector_checker_if #(.IN_W(2), .OUT_W(2), .ADDR_W(3)) bus_b ();
    assign bus_b.rom_data = rom_b[bus_b.rom_addr];
    assign bus_b.dut_out  = bus_b.dut_in;

    vector_checker #(.IN_W(2), .OUT_W(2), .ADDR_W(3), .SETTLE_CYC(SB), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mm_b),
        .err_count(err_b), .vec_count(vc_b), .first_err_addr(fe_b)
    );

    // Reference: walk the ROM until the first invalid word, apply the DUT function, count misses
    task automatic model_a(output int n, output int errs, output int first, output int dcyc,
                           output logic last_stim);
        logic resp;
        n = 0; errs = 0; first = 0; last_stim = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (rom_a[i][2] !== 1'b1) break;
            n++;
            last_stim = rom_a[i][1];
            resp = inv_a ? ~rom_a[i][1] : rom_a[i][1];
            if (resp !== rom_a[i][0]) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
        dcyc = n * (SA + 2) + ((n < 16) ? 2 : 1);
    endtask

    task automatic run_a(input bit hold, output int dcyc, output int mm, output int bcyc);
        dcyc = -1; mm = 0; bcyc = 0;
        start_a = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            start_a = hold;
            if (mm_a) mm++;
            if (busy_a) bcyc++;
            if (done_a) begin dcyc = c; break; end
        end
        start_a = 1'b0;
    endtask

    task automatic run_b(output int dcyc, output int mm);
        dcyc = -1; mm = 0;
        start_b = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (mm_b) mm++;
            if (done_b) begin dcyc = c; break; end
        end
    endtask

    task automatic test_reset();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_a); end
        total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL rst_pass got=%b want=0", pass_a); end
        total++; if (mm_a !== 1'b0) begin bad++; $display("FAIL rst_mismatch got=%b want=0", mm_a); end
        total++; if (err_a !== 8'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", err_a); end
        total++; if (vc_a !== 5'd0) begin bad++; $display("FAIL rst_vec got=%0d want=0", vc_a); end
        total++; if (fe_a !== 4'd0) begin bad++; $display("FAIL rst_first got=%0d want=0", fe_a); end
        total++; if (bus_a.dut_in !== 1'b0) begin bad++; $display("FAIL rst_dut_in got=%b want=0", bus_a.dut_in); end
        total++; if (bus_a.rom_addr !== 4'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", bus_a.rom_addr); end
        total++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL rst_b_flags got=%b%b want=00", done_b, busy_b); end
    endtask

    task automatic test_pass_through();
        int d, m, b;
        foreach (rom_a[i]) rom_a[i] = 3'b000;
        rom_a[0] = 3'b100; rom_a[1] = 3'b111; rom_a[2] = 3'b011;
        inv_a = 1'b0;
        run_a(1'b0, d, m, b);
        total++; if (d !== 10) begin bad++; $display("FAIL pt_done_cyc got=%0d want=10", d); end
        total++; if (vc_a !== 5'd2) begin bad++; $display("FAIL pt_vec got=%0d want=2", vc_a); end
        total++; if (err_a !== 8'd0) begin bad++; $display("FAIL pt_err got=%0d want=0", err_a); end
        total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL pt_pass got=%b want=1", pass_a); end
        total++; if (m !== 0) begin bad++; $display("FAIL pt_mm_pulses got=%0d want=0", m); end
        total++; if (b !== 9) begin bad++; $display("FAIL pt_busy_cyc got=%0d want=9", b); end
        total++; if (bus_a.dut_in !== 1'b1) begin bad++; $display("FAIL pt_dut_in_hold got=%b want=1", bus_a.dut_in); end
    endtask

    task automatic test_single_fail();
        int d, m, b;
        rom_a[1] = 3'b110;
        run_a(1'b0, d, m, b);
        total++; if (d !== 10) begin bad++; $display("FAIL sf_done_cyc got=%0d want=10", d); end
        total++; if (m !== 1) begin bad++; $display("FAIL sf_mm_pulses got=%0d want=1", m); end
        total++; if (err_a !== 8'd1) begin bad++; $display("FAIL sf_err got=%0d want=1", err_a); end
        total++; if (fe_a !== 4'd1) begin bad++; $display("FAIL sf_first got=%0d want=1", fe_a); end
        total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL sf_pass got=%b want=0", pass_a); end
    endtask

    task automatic test_full_rom_inverter();
        int d, m, b;
        logic s;
        foreach (rom_a[i]) begin
            s = 1'($urandom);
            rom_a[i] = {1'b1, s, s};
        end
        inv_a = 1'b1;
        run_a(1'b0, d, m, b);
        total++; if (d !== 65) begin bad++; $display("FAIL full_done_cyc got=%0d want=65", d); end
        total++; if (vc_a !== 5'd16) begin bad++; $display("FAIL full_vec got=%0d want=16", vc_a); end
        total++; if (err_a !== 8'd16) begin bad++; $display("FAIL full_err got=%0d want=16", err_a); end
        total++; if (fe_a !== 4'd0) begin bad++; $display("FAIL full_first got=%0d want=0", fe_a); end
        total++; if (m !== 16) begin bad++; $display("FAIL full_mm_pulses got=%0d want=16", m); end
    endtask

    task automatic test_reset_mid_run();
        int d, m, b;
        foreach (rom_a[i]) rom_a[i] = 3'b000;
        rom_a[0] = 3'b101; rom_a[1] = 3'b111; rom_a[2] = 3'b100; rom_a[3] = 3'b111;
        inv_a = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b want=1", busy_a); end
        total++; if (err_a !== 8'd1) begin bad++; $display("FAIL mid_pre_err got=%0d want=1", err_a); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if ({busy_a, done_a, pass_a, mm_a} !== 4'b0000) begin bad++; $display("FAIL mid_flags got=%b want=0000", {busy_a, done_a, pass_a, mm_a}); end
        total++; if ({err_a, vc_a, fe_a} !== 17'd0) begin bad++; $display("FAIL mid_counters got=%0d/%0d/%0d want=0/0/0", err_a, vc_a, fe_a); end
        total++; if ({bus_a.dut_in, bus_a.rom_addr} !== 5'd0) begin bad++; $display("FAIL mid_bus got=%b/%0d want=0/0", bus_a.dut_in, bus_a.rom_addr); end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy_a, done_a} !== 2'b00) begin bad++; $display("FAIL mid_idle got=%b want=00", {busy_a, done_a}); end
        run_a(1'b0, d, m, b);
        total++; if (d !== 18) begin bad++; $display("FAIL mid_rerun_cyc got=%0d want=18", d); end
        total++; if (vc_a !== 5'd4 || err_a !== 8'd1 || fe_a !== 4'd0) begin bad++; $display("FAIL mid_rerun_counts got=%0d/%0d/%0d want=4/1/0", vc_a, err_a, fe_a); end
    endtask

    task automatic test_start_hold();
        int d1, m1, b1, d2, m2, b2;
        foreach (rom_a[i]) rom_a[i] = 3'b000;
        rom_a[0] = 3'b100; rom_a[1] = 3'b110; rom_a[2] = 3'b100;
        inv_a = 1'b0;
        run_a(1'b1, d1, m1, b1);
        total++; if (d1 !== 14) begin bad++; $display("FAIL hold_done_cyc got=%0d want=14", d1); end
        total++; if (b1 !== 13) begin bad++; $display("FAIL hold_busy_cyc got=%0d want=13", b1); end
        total++; if (vc_a !== 5'd3 || err_a !== 8'd1 || fe_a !== 4'd1) begin bad++; $display("FAIL hold_counts got=%0d/%0d/%0d want=3/1/1", vc_a, err_a, fe_a); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (done_a !== 1'b1 || vc_a !== 5'd3) begin bad++; $display("FAIL hold_done_held got=%b/%0d want=1/3", done_a, vc_a); end
        run_a(1'b0, d2, m2, b2);
        total++; if (d2 !== 14 || m2 !== 1) begin bad++; $display("FAIL hold_rerun got=%0d/%0d want=14/1", d2, m2); end
        total++; if (vc_a !== 5'd3 || err_a !== 8'd1 || fe_a !== 4'd1) begin bad++; $display("FAIL hold_rerun_counts got=%0d/%0d/%0d want=3/1/1", vc_a, err_a, fe_a); end
    endtask

    task automatic test_terminator_zero();
        int d, m, b;
        foreach (rom_a[i]) rom_a[i] = 3'b111;
        rom_a[0] = 3'b011;
        run_a(1'b0, d, m, b);
        total++; if (d !== 2) begin bad++; $display("FAIL term0_done_cyc got=%0d want=2", d); end
        total++; if (vc_a !== 5'd0 || pass_a !== 1'b1) begin bad++; $display("FAIL term0_result got=%0d/%b want=0/1", vc_a, pass_a); end
    endtask

    task automatic test_saturation();
        int d, m, k;
        logic [1:0] s, f;
        foreach (rom_b[i]) rom_b[i] = 5'd0;
        for (int i = 0; i < 5; i++) begin
            s = 2'($urandom);
            rom_b[i] = {1'b1, s, ~s};
        end
        run_b(d, m);
        total++; if (d !== 27) begin bad++; $display("FAIL sat_done_cyc got=%0d want=27", d); end
        total++; if (err_b !== 2'd3) begin bad++; $display("FAIL sat_err got=%0d want=3", err_b); end
        total++; if (vc_b !== 4'd5) begin bad++; $display("FAIL sat_vec got=%0d want=5", vc_b); end
        total++; if (m !== 5 || pass_b !== 1'b0) begin bad++; $display("FAIL sat_pulses_pass got=%0d/%b want=5/0", m, pass_b); end
        k = $urandom_range(1, 7);
        f = 2'($urandom_range(1, 3));
        for (int i = 0; i < 8; i++) begin
            s = 2'($urandom);
            rom_b[i] = {1'b1, s, (i == k) ? (s ^ f) : s};
        end
        run_b(d, m);
        total++; if (d !== 41) begin bad++; $display("FAIL fullb_done_cyc got=%0d want=41", d); end
        total++; if (vc_b !== 4'd8 || err_b !== 2'd1 || fe_b !== 3'(k)) begin bad++; $display("FAIL fullb_counts got=%0d/%0d/%0d want=8/1/%0d", vc_b, err_b, fe_b, k); end
    endtask

    task automatic test_random();
        int d, m, b, n, e, fst, dc, term;
        logic ls;
        for (int it = 0; it < 8; it++) begin
            inv_a = 1'($urandom);
            term  = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) rom_a[i] = {(i < term) ? 1'b1 : 1'b0, 2'($urandom)};
            model_a(n, e, fst, dc, ls);
            run_a(1'($urandom), d, m, b);
            total++; if (d !== dc) begin bad++; $display("FAIL rnd%0d_done_cyc got=%0d want=%0d", it, d, dc); end
            total++; if (vc_a !== 5'(n)) begin bad++; $display("FAIL rnd%0d_vec got=%0d want=%0d", it, vc_a, n); end
            total++; if (err_a !== 8'(e) || m !== e) begin bad++; $display("FAIL rnd%0d_err got=%0d/%0d want=%0d", it, err_a, m, e); end
            total++; if (fe_a !== 4'(fst)) begin bad++; $display("FAIL rnd%0d_first got=%0d want=%0d", it, fe_a, fst); end
            total++; if (pass_a !== (e == 0)) begin bad++; $display("FAIL rnd%0d_pass got=%b want=%b", it, pass_a, (e == 0)); end
            if (n > 0) begin
                total++; if (bus_a.dut_in !== ls) begin bad++; $display("FAIL rnd%0d_dut_in got=%b want=%b", it, bus_a.dut_in, ls); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; inv_a = 1'b0;
        foreach (rom_a[i]) rom_a[i] = 3'b000;
        foreach (rom_b[i]) rom_b[i] = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        test_pass_through();
        test_single_fail();
        test_full_rom_inverter();
        test_reset_mid_run();
        test_start_hold();
        test_terminator_zero();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable self-checking stimulus engine for small single-bit-style DUTs such as the chapter 4 latch and flip-flop exercises. It walks a test-vector ROM and drives each vector's stimulus field into the DUT. After a programmable settle time it compares the DUT response against the vector's expected field and accumulates an error count. It replaces the simulation-only `$readmemb`/`$display` loop, so the same vectors can be run on an FPGA with pass/fail shown on LEDs.

## Interface

Parameters:
- IN_W, 1, stimulus field width (bits driven into DUT)
- OUT_W, 1, expected/response field width
- ADDR_W, 4, ROM address width; ROM depth is 2**ADDR_W
- SETTLE_CYC, 2, cycles between stimulus apply and check; legal range 1..255
- ERR_W, 8, error counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-low
- start  in  1  begin a run; sampled only in IDLE or DONE
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  1+IN_W+OUT_W  combinational ROM data, format {valid, stim, expected}
- dut_in  out  IN_W  registered stimulus to DUT
- dut_out  in  OUT_W  DUT response
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  done and err_count==0
- mismatch  out  1  one-cycle pulse on each failing check
- err_count  out  ERR_W  failing checks this run, saturating
- vec_count  out  ADDR_W+1  vectors checked this run
- first_err_addr  out  ADDR_W  address of first failing vector; 0 if none

## Operation

- FSM states: IDLE, FETCH, SETTLE, CHECK, DONE.
- IDLE, start=1 -> FETCH. The transition clears idx, err_count, vec_count, first_err_addr and the first-error flag.
- FETCH, one cycle: rom_addr=idx.
  - If rom_data valid bit is 0 -> DONE. This is the terminator; the word is not checked and not counted.
  - Otherwise register stim into dut_in, register expected into exp_reg, load settle counter with SETTLE_CYC-1 -> SETTLE.
- SETTLE: decrement the counter each cycle. Counter==0 -> CHECK.
- CHECK, one cycle: compare dut_out against exp_reg, all bits with exact equality.
  - On mismatch: pulse mismatch. Increment err_count, holding at 2**ERR_W-1. If this is the first error, capture idx into first_err_addr.
  - Always increment vec_count.
  - If idx==2**ADDR_W-1 -> DONE, covering a full ROM with no terminator. Otherwise idx+1 -> FETCH.
- DONE:
  - done=1; pass=(err_count==0).
  - dut_in holds its last value.
  - start=1 clears the counters and goes to FETCH, as from IDLE.
- start is ignored in FETCH, SETTLE and CHECK.
- rom_addr always equals idx.

## Timing

- Reset (reset==0 at a clk edge), from any state including mid-run:
  - state=IDLE, idx=0, dut_in=0.
  - busy, done, pass and mismatch = 0.
  - err_count, vec_count and first_err_addr = 0.
- busy=1 in FETCH, SETTLE and CHECK; busy=0 in IDLE and DONE.
- Each vector takes SETTLE_CYC+2 cycles: 1 FETCH, SETTLE_CYC SETTLE, 1 CHECK.
- dut_in changes on the edge that leaves FETCH, and is stable for SETTLE_CYC+1 edges before the CHECK compare edge. The DUT path must therefore settle within SETTLE_CYC cycles.
- A run of N valid vectors followed by a terminator asserts done N*(SETTLE_CYC+2)+2 cycles after the start edge: one cycle to reach FETCH, plus one for the terminator FETCH.
- mismatch is registered. It is high for exactly the cycle after a failing CHECK edge.
- err_count and vec_count update on the CHECK edge and are visible in the following cycle.
- A terminator at address 0 goes FETCH -> DONE with vec_count=0 and pass=1.

## Test plan

- Pass-through DUT (dut_out=dut_in), SETTLE_CYC=2, ROM {1,0,0},{1,1,1},{0,x,x} -> done after 10 cycles, vec_count=2, err_count=0, pass=1, mismatch never high.
- Same ROM with the second vector's expected field flipped to 0 -> one mismatch pulse, err_count=1, first_err_addr=1, pass=0.
- Full 16-entry ROM, no terminator, inverter DUT, all vectors failing -> vec_count=16, err_count=16, first_err_addr=0, done after 16*4+1 cycles.
- Drive reset low during the third vector's SETTLE -> next cycle all outputs 0 and state IDLE. A fresh start reruns from address 0 with clean counters.
- start held high throughout the run and raised again in DONE -> no restart while busy. From DONE, counters clear and a second identical run reports identical results.
- ERR_W=2 with 5 failing vectors -> err_count saturates at 3; vec_count=5.
